reset_sequencer: RTL and testbench

- Upstream reset-generation stage for the team's synchronous-reset flops.
- Converts a raw, asynchronous, possibly bouncy external reset request into clean, synchronous, active-high per-domain resets. Each `rst_out` bit drives the `rst` input of a downstream synchronous-reset register group.
- Releases the domains in a fixed, staggered order after a minimum hold time. Reports sequencing status.

---
 rtl/reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_reset_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes and debounces an external reset request and
// releases NUM_DOMAINS synchronous resets in a staggered order after a hold time.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned NUM_DOMAINS     = 3,
  parameter int unsigned STAGGER_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STAG_W = $clog2(STAGGER_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_IDLE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   req_s;
  logic [NUM_DOMAINS-1:0] rst_shift;

  assign req_s     = sync_q[SYNC_STAGES-1];
  // Releasing the next domain is a left shift of the thermometer code.
  assign rst_shift = rst_out_q << 1;

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rst_req};
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    rst_out_d  = rst_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        if (!req_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end

      ST_HOLD: begin
        if (req_s) begin
          state_d    = ST_ASSERT;
          rst_out_d  = '1;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          rst_out_d  = rst_shift;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          if (rst_shift == '0) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            deb_cnt_d = '0;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (hold_cnt_q != HOLD_W'(HOLD_CYCLES)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        if (req_s) begin
          state_d    = ST_ASSERT;
          rst_out_d  = '1;
          hold_cnt_d = '0;
          stag_cnt_d = '0;
        end else if (stag_cnt_q == STAG_W'(STAGGER_CYCLES - 1)) begin
          rst_out_d  = rst_shift;
          stag_cnt_d = '0;
          if (rst_shift == '0) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            deb_cnt_d = '0;
          end
        end else if (stag_cnt_q != STAG_W'(STAGGER_CYCLES)) begin
          stag_cnt_d = stag_cnt_q + STAG_W'(1);
        end
      end

      ST_IDLE: begin
        rst_out_d = '0;
        if (!req_s) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d   = ST_ASSERT;
          rst_out_d = '1;
          deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: begin
        state_d   = ST_ASSERT;
        rst_out_d = '1;
      end
    endcase

    busy_d = |rst_out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ASSERT;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      deb_cnt_q  <= '0;
      rst_out_q  <= '1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      rst_out_q  <= rst_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a minimal-parameter instance,
// both checked every cycle against a timeline-based reference model.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int A_N    = 3;
  localparam int A_HOLD = 8;
  localparam int A_DEB  = 4;
  localparam int A_STAG = 2;
  localparam int B_N    = 1;
  localparam int B_HOLD = 1;
  localparam int B_DEB  = 1;
  localparam int B_STAG = 2;

  localparam int M_ASSERTED = 0;
  localparam int M_SEQ      = 1;
  localparam int M_IDLE     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           rst_req;
  logic [A_N-1:0] a_out;
  logic           a_busy, a_done;
  logic [B_N-1:0] b_out;
  logic           b_busy, b_done;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(A_DEB), .HOLD_CYCLES(A_HOLD),
    .NUM_DOMAINS(A_N), .STAGGER_CYCLES(A_STAG)
  ) dut_a (
    .clk(clk), .rst(rst), .rst_req(rst_req),
    .rst_out(a_out), .busy(a_busy), .done(a_done)
  );

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(B_DEB), .HOLD_CYCLES(B_HOLD),
    .NUM_DOMAINS(B_N), .STAGGER_CYCLES(B_STAG)
  ) dut_b (
    .clk(clk), .rst(rst), .rst_req(rst_req),
    .rst_out(b_out), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: request history, a mode, and time since hold entry.
  int              m_mode [2];
  int              m_t    [2];
  int              m_run  [2];
  logic [SYNC-1:0] m_hist [2];
  logic [7:0]      m_out  [2];
  logic            m_busy [2];
  logic            m_done [2];

  function automatic logic [7:0] ones(input int n);
    return 8'((1 << n) - 1);
  endfunction

  task automatic model_step(input int i, input logic r, input logic q);
    int n, hold, deb, stag, rel;
    logic rs;
    n    = (i == 0) ? A_N    : B_N;
    hold = (i == 0) ? A_HOLD : B_HOLD;
    deb  = (i == 0) ? A_DEB  : B_DEB;
    stag = (i == 0) ? A_STAG : B_STAG;
    m_done[i] = 1'b0;
    if (r) begin
      m_hist[i] = '0;
      m_mode[i] = M_ASSERTED;
      m_t[i]    = 0;
      m_run[i]  = 0;
      m_out[i]  = ones(n);
    end else begin
      rs = m_hist[i][SYNC-1];
      case (m_mode[i])
        M_ASSERTED: begin
          m_out[i] = ones(n);
          if (!rs) begin
            m_mode[i] = M_SEQ;
            m_t[i]    = 0;
          end
        end
        M_SEQ: begin
          if (rs) begin
            m_mode[i] = M_ASSERTED;
            m_out[i]  = ones(n);
          end else begin
            m_t[i] = m_t[i] + 1;
            rel = (m_t[i] >= hold) ? ((m_t[i] - hold) / stag + 1) : 0;
            if (rel > n) rel = n;
            m_out[i] = ones(n) & ~ones(rel);
            if (rel == n) begin
              m_mode[i] = M_IDLE;
              m_done[i] = 1'b1;
              m_run[i]  = 0;
            end
          end
        end
        default: begin
          m_out[i] = '0;
          m_run[i] = rs ? m_run[i] + 1 : 0;
          if (m_run[i] >= deb) begin
            m_mode[i] = M_ASSERTED;
            m_out[i]  = ones(n);
            m_run[i]  = 0;
          end
        end
      endcase
      m_hist[i] = {m_hist[i][SYNC-2:0], q};
    end
    m_busy[i] = (m_out[i] != 8'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [A_N-1:0] th;
    th = (a_out << 1) & ~a_out;
    chk("a_rst_out", 32'(a_out), 32'(m_out[0]));
    chk("a_busy", 32'(a_busy), 32'(m_busy[0]));
    chk("a_done", 32'(a_done), 32'(m_done[0]));
    chk("b_rst_out", 32'(b_out), 32'(m_out[1]));
    chk("b_busy", 32'(b_busy), 32'(m_busy[1]));
    chk("b_done", 32'(b_done), 32'(m_done[1]));
    chk("a_thermometer", 32'(th), 32'd0);
    chk("a_done_while_busy", 32'(a_done & a_busy), 32'd0);
    chk("b_done_while_busy", 32'(b_done & b_busy), 32'd0);
  endtask

  task automatic tick(input logic r, input logic q);
    rst     = r;
    rst_req = q;
    @(posedge clk);
    model_step(0, r, q);
    model_step(1, r, q);
    #1;
    check_all();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((a_busy || b_busy) && k < budget) begin
      tick(1'b0, 1'b0);
      k++;
    end
    chk("wait_idle_timeout", 32'(a_busy | b_busy), 32'd0);
    tick(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       req;
    logic [2:0] out;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [17];
  int   seen, cnt, rem, guard;
  logic rq, rr;

  initial begin
    rst     = 1'b1;
    rst_req = 1'b0;

    // Power-on table: 3 reset cycles, then hold entry at index 3 (edge 0).
    for (int i = 0; i < 17; i++) begin
      vecs[i].rst = (i < 3);
      vecs[i].req = 1'b0;
      if (i < 3)       vecs[i].out = 3'b111;
      else if (i < 11) vecs[i].out = 3'b111;
      else if (i < 13) vecs[i].out = 3'b110;
      else if (i < 15) vecs[i].out = 3'b100;
      else             vecs[i].out = 3'b000;
      vecs[i].busy = (vecs[i].out != 3'b000);
      vecs[i].done = (i == 15);
    end
    for (int i = 0; i < 17; i++) begin
      tick(vecs[i].rst, vecs[i].req);
      chk("vec_rst_out", 32'(a_out), 32'(vecs[i].out));
      chk("vec_busy", 32'(a_busy), 32'(vecs[i].busy));
      chk("vec_done", 32'(a_done), 32'(vecs[i].done));
      if (i == 4) begin
        chk("min_param_release", 32'(b_out), 32'd0);
        chk("min_param_done", 32'(b_done), 32'd1);
      end
    end
    wait_idle(50);

    // Glitch of 3 cycles is rejected by the default instance.
    for (int k = 0; k < 13; k++) begin
      tick(1'b0, k < 3);
      chk("glitch_rst_out", 32'(a_out), 32'd0);
      chk("glitch_done", 32'(a_done), 32'd0);
    end
    wait_idle(50);

    // Request of exactly 4 cycles is accepted 5 edges after the first sample.
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, k < 4);
      if (k == 4) chk("debounce_not_yet", 32'(a_out), 32'd0);
      if (k == 5) chk("debounce_assert", 32'(a_out), 32'h7);
    end
    wait_idle(60);

    // Held request: asserted throughout, then full hold and release.
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b1);
      if (k >= 5) chk("held_rst_out", 32'(a_out), 32'h7);
    end
    seen = -1;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 1'b0);
      if (a_done && seen < 0) seen = k;
    end
    chk("held_done_latency", 32'(seen), 32'd14);
    wait_idle(50);

    // Re-request during release restarts the whole sequence.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1);
    guard = 0;
    while (a_out != 3'b110 && guard < 60) begin
      tick(1'b0, 1'b0);
      guard++;
    end
    chk("rereq_reached_110", 32'(a_out), 32'h6);
    cnt = 0;
    tick(1'b0, 1'b1);
    cnt += a_done;
    tick(1'b0, 1'b1);
    cnt += a_done;
    tick(1'b0, 1'b0);
    cnt += a_done;
    chk("rereq_reassert", 32'(a_out), 32'h7);
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0);
      cnt += a_done;
    end
    chk("rereq_done_count", 32'(cnt), 32'd1);
    wait_idle(50);

    // Reset during hold with hold_cnt = 5, then hold restarts from 0.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("midrst_rst_out", 32'(a_out), 32'h7);
    chk("midrst_busy", 32'(a_busy), 32'd1);
    chk("midrst_done", 32'(a_done), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0);
      if (k == 7) chk("midrst_hold_still", 32'(a_out), 32'h7);
      if (k == 8) chk("midrst_first_release", 32'(a_out), 32'h6);
    end
    wait_idle(50);

    // Random request bursts with occasional sequencer resets.
    rq  = 1'b0;
    rem = 0;
    for (int k = 0; k < 3000; k++) begin
      if (rem == 0) begin
        rq  = ~rq;
        rem = rq ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 25));
      end
      rem--;
      rr = ($urandom_range(0, 299) == 0);
      tick(rr, rq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
